// File: rtl/stopwatch_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : stopwatch_controller                                             |
// | Purpose : Run-control FSM for the DE0 stopwatch: gated tick prescaler,     |
// |           counter clear pulse and lap display-freeze control.              |
// | Config  : `define STOPWATCH_LAP_EN to build the LAP state / display_hold.  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module stopwatch_controller #(
    parameter int CLK_FREQ_HZ  = 50000000,
    parameter int TICK_FREQ_HZ = 100
) (
    input  logic clk,
    input  logic async_reset,
    input  logic start_stop_pulse,
    input  logic lap_pulse,
    input  logic clear_pulse,
    output logic tick,
    output logic count_clear,
    output logic display_hold,
    output logic running
);

    localparam int DIV = CLK_FREQ_HZ / TICK_FREQ_HZ;
    localparam int PW  = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] C_PRESC_MAX = PW'(DIV - 1);

    generate
        if ((DIV < 2) || ((CLK_FREQ_HZ % TICK_FREQ_HZ) != 0)) begin : g_bad_div
            $error("stopwatch_controller: CLK_FREQ_HZ/TICK_FREQ_HZ must be an integer >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
`ifdef STOPWATCH_LAP_EN
        ,ST_LAP  = 2'd3
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          clear_q, clear_d;
    logic          w_running;
    logic          w_wrap;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_stop_pulse) state_d = ST_RUN;
            ST_RUN: begin
                if (start_stop_pulse) state_d = ST_PAUSE;
`ifdef STOPWATCH_LAP_EN
                else if (lap_pulse)   state_d = ST_LAP;
`endif
            end
            ST_PAUSE: begin
                if (clear_pulse)           state_d = ST_IDLE;
                else if (start_stop_pulse) state_d = ST_RUN;
            end
`ifdef STOPWATCH_LAP_EN
            ST_LAP: begin
                if (start_stop_pulse) state_d = ST_PAUSE;
                else if (lap_pulse)   state_d = ST_RUN;
            end
`endif
            default:  state_d = ST_IDLE;
        endcase
    end

`ifdef STOPWATCH_LAP_EN
    assign w_running    = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign display_hold = (state_q == ST_LAP);
`else
    logic unused_lap_pulse;
    assign unused_lap_pulse = lap_pulse;
    assign w_running        = (state_q == ST_RUN);
    assign display_hold     = 1'b0;
`endif

    // A wrap on the edge that leaves RUN still issues its tick: that period was counted.
    assign w_wrap = w_running && (presc_q == C_PRESC_MAX);

    always_comb begin
        presc_d = presc_q;
        if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) begin
            presc_d = '0;
        end else if (w_wrap) begin
            presc_d = '0;
        end else if (w_running) begin
            presc_d = presc_q + PW'(1);
        end
        tick_d  = w_wrap;
        clear_d = (state_q == ST_PAUSE) && (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            tick_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            clear_q <= clear_d;
        end
    end

    assign tick        = tick_q;
    assign count_clear = clear_q;
    assign running     = w_running;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_stopwatch_controller                                          |
// | Purpose : Self-checking bench for stopwatch_controller (DIV = 10).         |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_stopwatch_controller;

    localparam int DIV     = 10;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_LAP   = 3;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic async_reset = 1'b0;
    logic ss = 1'b0, lp = 1'b0, cl = 1'b0;
    logic tick, count_clear, display_hold, running;
    logic [3:0] obs;

    stopwatch_controller #(.CLK_FREQ_HZ(10), .TICK_FREQ_HZ(1)) dut (
        .clk              (clk),
        .async_reset      (async_reset),
        .start_stop_pulse (ss),
        .lap_pulse        (lp),
        .clear_pulse      (cl),
        .tick             (tick),
        .count_clear      (count_clear),
        .display_hold     (display_hold),
        .running          (running)
    );

    always #5 clk = ~clk;
    assign obs = {running, display_hold, tick, count_clear};

    int total = 0;
    int bad   = 0;

    // Reference model: mode plus total running cycles since the last clear.
    int   m_mode    = M_IDLE;
    int   m_elapsed = 0;
    logic m_tick    = 1'b0;
    logic m_clear   = 1'b0;

    function automatic logic [3:0] exp_vec();
        return {(m_mode == M_RUN) || (m_mode == M_LAP), m_mode == M_LAP, m_tick, m_clear};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_elapsed = 0; m_tick = 1'b0; m_clear = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic l, input logic c);
        bit run;
        run     = (m_mode == M_RUN) || (m_mode == M_LAP);
        m_tick  = 1'b0;
        m_clear = 1'b0;
        if (run) begin
            m_elapsed++;
            m_tick = ((m_elapsed % DIV) == 0);
        end
        case (m_mode)
            M_IDLE:  if (s) m_mode = M_RUN;
            M_RUN:   if (s) m_mode = M_PAUSE; else if (l && LAP_EN) m_mode = M_LAP;
            M_PAUSE: if (c) begin m_mode = M_IDLE; m_clear = 1'b1; m_elapsed = 0; end
                     else if (s) m_mode = M_RUN;
            default: if (s) m_mode = M_PAUSE; else if (l) m_mode = M_RUN;
        endcase
    endtask

    // Present pulses for one clock edge, then return at the following negedge.
    task automatic drive(input logic s, input logic l, input logic c);
        ss = s; lp = l; cl = c;
        @(posedge clk);
        if (async_reset) model_edge(s, l, c);
        #1 ss = 1'b0; lp = 1'b0; cl = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        async_reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        async_reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (obs !== 4'b0000) begin bad++; $display("FAIL reset_outputs obs=%b exp=0000", obs); end
        drive(1'b1, 1'b1, 1'b1);
        total++;
        if (obs !== 4'b0000) begin bad++; $display("FAIL reset_pulse_discard obs=%b exp=0000", obs); end
        async_reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0);
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL reset_release obs=%b exp=%b", obs, exp_vec()); end
        end
    endtask

    task automatic test_start_ticks();
        int cyc;
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            drive(c == 5, 1'b0, 1'b0);
            cyc = c + 1;
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL start_model cyc=%0d obs=%b exp=%b", cyc, obs, exp_vec()); end
            total++;
            if (tick !== (cyc == 16 || cyc == 26 || cyc == 36) || running !== (cyc >= 6)) begin
                bad++; $display("FAIL start_ticks cyc=%0d tick=%b running=%b", cyc, tick, running);
            end
        end
    endtask

    task automatic test_pause_resume();
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            drive(1'b0, 1'b0, 1'b0);
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL pause_run obs=%b exp=%b", obs, exp_vec()); end
        end
        drive(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 1'b0);
            total++;
            if (running !== 1'b0 || tick !== 1'b0) begin bad++; $display("FAIL pause_hold running=%b tick=%b exp 0 0", running, tick); end
        end
        drive(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            drive(1'b0, 1'b0, 1'b0);
            total++;
            if (tick !== (k == 7) || obs !== exp_vec()) begin
                bad++; $display("FAIL resume_tick k=%0d obs=%b exp=%b", k, obs, exp_vec());
            end
        end
    endtask

    task automatic test_clear();
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        total++;
        if (count_clear !== 1'b1 || running !== 1'b0 || tick !== 1'b0) begin
            bad++; $display("FAIL clear_pulse cc=%b running=%b tick=%b exp 1 0 0", count_clear, running, tick);
        end
        drive(1'b0, 1'b1, 1'b1);
        total++;
        if (obs !== 4'b0000 || obs !== exp_vec()) begin bad++; $display("FAIL clear_once obs=%b exp=0000", obs); end
        drive(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            drive(1'b0, 1'b0, 1'b0);
            total++;
            if (tick !== (k == 10) || obs !== exp_vec()) begin
                bad++; $display("FAIL clear_restart k=%0d obs=%b exp=%b", k, obs, exp_vec());
            end
        end
    endtask

    task automatic test_lap();
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 15; k++) begin
            total++;
            if (display_hold !== LAP_EN || running !== 1'b1 || obs !== exp_vec()) begin
                bad++; $display("FAIL lap_hold k=%0d obs=%b exp=%b", k, obs, exp_vec());
            end
            drive(1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b1, 1'b0);
        total++;
        if (display_hold !== 1'b0 || running !== 1'b1) begin
            bad++; $display("FAIL lap_release hold=%b running=%b exp 0 1", display_hold, running);
        end
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        total++;
        if (obs !== exp_vec() || running !== 1'b0 || display_hold !== 1'b0) begin
            bad++; $display("FAIL lap_to_pause obs=%b exp=%b", obs, exp_vec());
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        total++;
        if (running !== 1'b1 || count_clear !== 1'b0 || obs !== exp_vec()) begin
            bad++; $display("FAIL run_clear_ignored obs=%b exp=%b", obs, exp_vec());
        end
        drive(1'b1, 1'b1, 1'b0);
        total++;
        if (running !== 1'b0 || display_hold !== 1'b0) begin
            bad++; $display("FAIL run_ss_over_lap running=%b hold=%b exp 0 0", running, display_hold);
        end
        drive(1'b1, 1'b1, 1'b1);
        total++;
        if (count_clear !== 1'b1 || running !== 1'b0 || obs !== exp_vec()) begin
            bad++; $display("FAIL pause_clear_priority obs=%b exp=%b", obs, exp_vec());
        end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        total++;
        if (obs !== exp_vec() || running !== 1'b0) begin
            bad++; $display("FAIL lap_ss_priority obs=%b exp=%b", obs, exp_vec());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        repeat (6) drive(1'b0, 1'b0, 1'b0);
        async_reset = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs !== 4'b0000) begin bad++; $display("FAIL async_reset_now obs=%b exp=0000", obs); end
        ss = 1'b1;
        @(posedge clk);
        #1 ss = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== 4'b0000) begin bad++; $display("FAIL async_reset_held obs=%b exp=0000", obs); end
        async_reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            drive(1'b0, 1'b0, 1'b0);
            total++;
            if (tick !== (k == 10) || obs !== exp_vec()) begin
                bad++; $display("FAIL post_reset_tick k=%0d obs=%b exp=%b", k, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 4) == 0);
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL random i=%0d obs=%b exp=%b", i, obs, exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_start_ticks();
        test_pause_resume();
        test_clear();
        test_lap();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
